// File: rtl/segment_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : segment_serial_adder_ctrl
//  Description : Serial sequencer that reuses one SEG_W-bit adder across the
//                WIDTH/SEG_W segments of an operand pair, LSB segment first.
//                The carry between segments either ripples (exact) or is
//                forced to 0 for every segment (approximate).
//  Revision    : 1.0 - initial release
// ============================================================================
module segment_serial_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             approx_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             busy_o
);

    localparam int c_NSEG  = WIDTH / SEG_W;
    // A one-segment configuration still needs a real (1-bit) counter.
    localparam int c_CNT_W = (c_NSEG > 1) ? $clog2(c_NSEG) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NSEG - 1);

    // Reject segment widths that do not tile the operand exactly.
    generate
        if ((SEG_W < 1) || ((WIDTH % SEG_W) != 0)) begin : g_bad_seg_w
            $error("segment_serial_adder_ctrl: SEG_W must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_in_ready;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic               r_carry_out;
    logic               r_approx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;

    logic [SEG_W-1:0]   w_a_seg;
    logic [SEG_W-1:0]   w_b_seg;
    logic               w_cin;
    logic [SEG_W:0]     w_seg_sum;
    logic               w_last;
    logic               w_accept;

    // A new pair can only be taken while the registered ready is high (IDLE).
    assign w_accept = in_valid_i & r_in_ready;
    assign w_last   = (r_cnt == c_LAST);
    assign w_cin    = r_approx ? 1'b0 : r_carry;

    // Select the operand segment addressed by the counter.
    always_comb begin
        w_a_seg = '0;
        w_b_seg = '0;
        for (int s = 0; s < c_NSEG; s++) begin
            if (r_cnt == c_CNT_W'(s)) begin
                w_a_seg = r_a[s*SEG_W +: SEG_W];
                w_b_seg = r_b[s*SEG_W +: SEG_W];
            end
        end
    end

    // The shared SEG_W-bit adder, widened by one bit to expose its carry-out.
    assign w_seg_sum = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SEG_W{1'b0}}, w_cin};

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_next_state = S_RUN;
            S_RUN:   if (w_last)      w_next_state = S_DONE;
            S_DONE:  if (out_ready_i) w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered ready: high exactly when the next state is IDLE, so it stays
    // low during reset and rises on the first edge after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == S_IDLE);
        end
    end

    // Operand capture and one-segment-per-cycle accumulation of the result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a         <= '0;
            r_b         <= '0;
            r_approx    <= 1'b0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_sum       <= '0;
        end else if (w_accept) begin
            r_a      <= a_i;
            r_b      <= b_i;
            r_approx <= approx_i;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
            r_carry <= w_seg_sum[SEG_W];
            for (int s = 0; s < c_NSEG; s++) begin
                if (r_cnt == c_CNT_W'(s)) begin
                    r_sum[s*SEG_W +: SEG_W] <= w_seg_sum[SEG_W-1:0];
                end
            end
            // The visible carry only changes when the top segment lands, so it
            // keeps the previous result while a new transaction is running.
            if (w_last) begin
                r_carry_out <= w_seg_sum[SEG_W];
            end
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign sum_o       = r_sum;
    assign carry_o     = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_segment_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_segment_serial_adder_ctrl
//  Description : Self-checking bench for segment_serial_adder_ctrl with a
//                transaction-level reference model and directed corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_serial_adder_ctrl;

    localparam int WIDTH = 32;
    localparam int SEG_W = 8;
    localparam int NSEG  = WIDTH / SEG_W;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             approx_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             busy_o;

    segment_serial_adder_ctrl #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .approx_i   (approx_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .sum_o      (sum_o),
        .carry_o    (carry_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edge   = 0;
    int n_acc    = 0;
    int n_done   = 0;

    always @(posedge clk_i) n_edge++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact WIDTH-bit add, or independent per-segment adds with
    // the carry-out of the top segment as the reported carry.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic ap);
        logic [WIDTH:0] r;
        logic [SEG_W:0] seg;
        if (!ap) return {1'b0, a} + {1'b0, b};
        r = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg = {1'b0, a[s*SEG_W +: SEG_W]} + {1'b0, b[s*SEG_W +: SEG_W]};
            r[s*SEG_W +: SEG_W] = seg[SEG_W-1:0];
            if (s == NSEG - 1) r[WIDTH] = seg[SEG_W];
        end
        return r;
    endfunction

    // Transaction-level model, evaluated on every falling edge.
    bit             m_busy = 1'b0;
    bit             m_ready = 1'b0;
    int             m_done_edge = 0;
    logic [WIDTH:0] m_exp = '0;
    logic [WIDTH:0] m_last = '0;

    initial begin
        bit exp_valid;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                check("reset outputs", {in_ready_o, out_valid_o, busy_o, carry_o, sum_o}, '0);
                m_busy  = 1'b0;
                m_ready = 1'b0;
                m_last  = '0;
                n_acc   = n_done;
            end else begin
                exp_valid = m_busy && (n_edge >= m_done_edge);
                check("in_ready", in_ready_o, m_ready);
                check("busy", busy_o, m_busy);
                check("out_valid", out_valid_o, exp_valid);
                if (exp_valid)
                    check("result", {carry_o, sum_o}, m_exp);
                else if (!m_busy)
                    check("held result", {carry_o, sum_o}, m_last);
                if (m_ready && in_valid_i) begin
                    m_busy      = 1'b1;
                    m_done_edge = n_edge + 1 + NSEG;
                    m_exp       = ref_add(a_i, b_i, approx_i);
                    n_acc++;
                end else if (exp_valid && out_ready_i) begin
                    m_busy = 1'b0;
                    m_last = m_exp;
                    n_done++;
                end
                m_ready = !m_busy;
            end
        end
    end

    // Called #1 after a rising edge; returns at the same phase with ready high.
    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        check({name, " ready timeout"}, ok, 1'b1);
    endtask

    // Wait (bounded) for out_valid at a falling edge.
    task automatic wait_valid(input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (out_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        check({name, " valid timeout"}, got, 1'b1);
    endtask

    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic ap, input logic [WIDTH-1:0] esum,
                           input logic ec, input string name);
        int acc_edge;
        bit got;
        wait_ready(name);
        in_valid_i  = 1'b1;
        a_i         = a;
        b_i         = b;
        approx_i    = ap;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        acc_edge   = n_edge;
        in_valid_i = 1'b0;
        a_i        = $urandom;
        b_i        = $urandom;
        approx_i   = ~ap;
        wait_valid(name, got);
        if (got) begin
            check({name, " latency"}, n_edge - acc_edge, 4);
            check({name, " sum"}, sum_o, esum);
            check({name, " carry"}, carry_o, ec);
        end
        @(posedge clk_i); #1;
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom % 8)
            0:       return '1;
            1:       return '0;
            2:       return {{(WIDTH-SEG_W){1'b0}}, {SEG_W{1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit got;
        int target;

        // Reset state and registered ready after release.
        repeat (2) @(posedge clk_i);
        #1;
        check("reset in_ready", in_ready_o, 1'b0);
        check("reset sum", {carry_o, sum_o}, '0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready before first edge", in_ready_o, 1'b0);
        @(posedge clk_i); #1;
        check("ready after release", in_ready_o, 1'b1);

        // Directed carry-mode corners.
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "exact wrap");
        run_txn(32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, "approx drop");
        run_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, "exact ripple");
        run_txn(32'hFF00_0000, 32'h0100_0000, 1'b1, 32'h0000_0000, 1'b1, "approx top");
        run_txn(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789, 1'b0, "approx plain");

        // Backpressure: result held and new pair ignored while DONE stalls.
        wait_ready("bp");
        in_valid_i  = 1'b1;
        a_i         = 32'h8000_0000;
        b_i         = 32'h8000_0000;
        approx_i    = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        a_i = 32'd5;
        b_i = 32'd7;
        wait_valid("bp first", got);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp valid held", out_valid_o, 1'b1);
            check("bp ready low", in_ready_o, 1'b0);
            check("bp result held", {carry_o, sum_o}, {1'b1, 32'h0000_0000});
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp ready after release", in_ready_o, 1'b1);
        check("bp idle", busy_o, 1'b0);
        @(posedge clk_i); #1;
        check("bp new accepted", busy_o, 1'b1);
        in_valid_i = 1'b0;
        wait_valid("bp second", got);
        if (got) check("bp second result", {carry_o, sum_o}, {1'b0, 32'd12});
        @(posedge clk_i); #1;

        // Reset during the second RUN cycle discards the transaction.
        wait_ready("rst");
        in_valid_i = 1'b1;
        a_i        = 32'hDEAD_BEEF;
        b_i        = 32'h0123_4567;
        approx_i   = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("async reset outputs", {in_ready_o, out_valid_o, busy_o, carry_o, sum_o}, '0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("ready low after release", in_ready_o, 1'b0);
        @(posedge clk_i); #1;
        check("ready one edge after release", in_ready_o, 1'b1);
        run_txn(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, "post reset");

        // Randomized traffic with stalls on both sides.
        target = n_done + 1000;
        for (int cyc = 0; cyc < 60000 && n_done < target; cyc++) begin
            in_valid_i  = ($urandom % 4) != 0;
            a_i         = pick_operand();
            b_i         = pick_operand();
            approx_i    = $urandom % 2;
            out_ready_i = ($urandom % 3) != 0;
            @(posedge clk_i); #1;
        end
        check("random completed", n_done >= target, 1'b1);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        check("no lost transactions", n_acc, n_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/segment_serial_adder_ctrl.md
Name: segment_serial_adder_ctrl

Overview:
- Sequencer that time-multiplexes one SEG_W-bit adder datapath across NSEG = WIDTH/SEG_W segments of a WIDTH-bit operand pair, LSB segment first.
- Supports two carry modes, latched per transaction:
  - exact: the segment carry ripples between segments.
  - approximate: equal-segmentation style; the carry-in of every segment is forced to 0.
- Serves as the low-area controller wrapper around the team's segmented approximate adders, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- SEG_W, 8, segment width in bits. Must divide WIDTH exactly; any other value is an elaboration error.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  block can accept an operand pair.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- approx_i  input  1  1 = approximate mode (segment carry-ins forced to 0), 0 = exact mode.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- sum_o  output  WIDTH  result sum.
- carry_o  output  1  carry out of the top segment.
- busy_o  output  1  high while a transaction is in RUN or DONE.

Behaviour:
- Reset:
  - Asserting rst_i at any time, including mid-RUN or in DONE, forces state=IDLE and clears the segment counter, the carry register, the operand registers and the sum register to 0.
  - Output values during reset: in_ready_o=0, out_valid_o=0, sum_o=0, carry_o=0, busy_o=0.
  - in_ready_o is registered and rises on the first clock edge after rst_i deasserts.
  - Any in-flight transaction is discarded and never reported.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o at an edge, capture a_i, b_i and approx_i, clear the counter and the carry register, and go to RUN.
  - in_ready_o drops at the same edge.
- RUN (one segment per cycle, k = counter):
  - seg_sum = a[k] + b[k] + (approx ? 0 : carry), computed as SEG_W+1 bits.
  - Write seg_sum[SEG_W-1:0] into sum bits [k*SEG_W +: SEG_W].
  - Carry register <= seg_sum[SEG_W].
  - Counter increments.
  - After segment NSEG-1 is written, go to DONE.
  - In approximate mode, carry-outs of lower segments are discarded.
- Latency:
  - With the accept at edge N, segments are written at edges N+1 .. N+NSEG.
  - out_valid_o is high from edge N+NSEG; the default configuration gives 4 cycles.
- DONE:
  - out_valid_o=1.
  - sum_o, and carry_o = carry out of segment NSEG-1, are held stable until out_valid_o & out_ready_i at an edge.
  - On that edge, go to IDLE; out_valid_o drops and in_ready_o rises.
- Backpressure: in_ready_o=0 in RUN and DONE, and in_valid_i is ignored there. This gives a maximum throughput of one transaction per NSEG+2 cycles.
- Operands changing on a_i/b_i after acceptance do not affect the result.
- sum_o and carry_o keep the last result after the handshake, until the next transaction overwrites them segment by segment.
- Corner case NSEG=1: RUN lasts exactly one cycle. The counter is at least 1 bit wide.
- busy_o = (state != IDLE).

Test Plan:
- Exact wrap: a=0xFFFFFFFF, b=0x00000001, approx=0 -> sum_o=0x00000000, carry_o=1, out_valid_o rises exactly 4 edges after the accept edge.
- Approximate carry drop: a=0x000000FF, b=0x00000001, approx=1 -> sum_o=0x00000000, carry_o=0. The same operands with approx=0 -> sum_o=0x00000100, carry_o=0.
- Approximate top carry: a=0xFF000000, b=0x01000000, approx=1 -> sum_o=0x00000000, carry_o=1. Also a=0x12345678, b=0x11111111, approx=1 -> sum_o=0x23456789, carry_o=0.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE while driving in_valid_i=1 with new operands -> sum_o and carry_o stable, in_ready_o=0, new operands not accepted. Then raise out_ready_i -> IDLE, and the new pair is accepted on the next edge.
- Reset mid-operation: assert rst_i during the 2nd RUN cycle -> all outputs 0 immediately (asynchronous), no out_valid_o afterwards. in_ready_o=1 one edge after release, and the next transaction gives a correct result.
- Back-to-back random: 1000 random transactions with random approx and random in_valid_i/out_ready_i stalls -> every result matches the reference model (exact add, or per-segment add with carry-ins forced to 0) and no transaction is lost or duplicated.
